// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - SHA-256 message schedule and round sequencer (optional SHA256_BYTE_SWAP_EN)
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] w_out,
    output logic [31:0] k_out,
    output logic        round_valid,
    output logic        compress_start,
    output logic        update_hash,
    output logic        block_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_t;

    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         word_cnt_q, word_cnt_d;
    logic [5:0]         t_q, t_d;
    logic [15:0][31:0]  window_q, window_d;
    logic [31:0]        w_out_q, w_out_d;
    logic [31:0]        k_out_q, k_out_d;
    logic               s_ready_q, s_ready_d;
    logic               round_valid_q, round_valid_d;
    logic               compress_start_q, compress_start_d;
    logic               update_hash_q, update_hash_d;
    logic               block_done_q, block_done_d;
    logic               busy_q, busy_d;

    logic [31:0]        data_in;
    logic [31:0]        w_new;

`ifdef SHA256_BYTE_SWAP_EN
    assign data_in = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
`else
    assign data_in = s_data;
`endif

    // In ROUND at round t the window holds W[t..t+15]; this is W[t+16].
    assign w_new = sig1(window_q[14]) + window_q[9] + sig0(window_q[1]) + window_q[0];

    // Next-state and registered-output computation for LOAD/ROUND/FINAL.
    always_comb begin
        state_d          = state_q;
        word_cnt_d       = word_cnt_q;
        t_d              = t_q;
        window_d         = window_q;
        w_out_d          = w_out_q;
        k_out_d          = k_out_q;
        s_ready_d        = s_ready_q;
        round_valid_d    = round_valid_q;
        compress_start_d = compress_start_q;
        update_hash_d    = 1'b0;
        block_done_d     = 1'b0;
        busy_d           = busy_q;
        case (state_q)
            ST_LOAD: begin
                if (s_valid && s_ready_q) begin
                    window_d   = {data_in, window_q[15:1]};
                    word_cnt_d = word_cnt_q + 4'd1;
                    busy_d     = 1'b1;
                    if (word_cnt_q == 4'd15) begin
                        // window_q[1] becomes window entry 0 after this shift, i.e. W[0].
                        state_d          = ST_ROUND;
                        word_cnt_d       = 4'd0;
                        t_d              = 6'd0;
                        s_ready_d        = 1'b0;
                        round_valid_d    = 1'b1;
                        compress_start_d = 1'b0;
                        w_out_d          = window_q[1];
                        k_out_d          = K_ROM[0];
                    end
                end
            end
            ST_ROUND: begin
                window_d         = {w_new, window_q[15:1]};
                compress_start_d = 1'b1;
                if (t_q == T_LAST) begin
                    state_d       = ST_FINAL;
                    round_valid_d = 1'b0;
                    update_hash_d = 1'b1;
                    block_done_d  = 1'b1;
                end else begin
                    t_d     = t_q + 6'd1;
                    w_out_d = window_q[1];
                    k_out_d = K_ROM[t_q + 6'd1];
                end
            end
            ST_FINAL: begin
                state_d          = ST_LOAD;
                word_cnt_d       = 4'd0;
                s_ready_d        = 1'b1;
                compress_start_d = 1'b0;
                busy_d           = 1'b0;
            end
            default: begin
                state_d          = ST_LOAD;
                word_cnt_d       = 4'd0;
                s_ready_d        = 1'b1;
                round_valid_d    = 1'b0;
                compress_start_d = 1'b0;
                busy_d           = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any partial block immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_LOAD;
            word_cnt_q       <= 4'd0;
            t_q              <= 6'd0;
            window_q         <= '0;
            w_out_q          <= 32'h0;
            k_out_q          <= 32'h0;
            s_ready_q        <= 1'b1;
            round_valid_q    <= 1'b0;
            compress_start_q <= 1'b0;
            update_hash_q    <= 1'b0;
            block_done_q     <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            word_cnt_q       <= word_cnt_d;
            t_q              <= t_d;
            window_q         <= window_d;
            w_out_q          <= w_out_d;
            k_out_q          <= k_out_d;
            s_ready_q        <= s_ready_d;
            round_valid_q    <= round_valid_d;
            compress_start_q <= compress_start_d;
            update_hash_q    <= update_hash_d;
            block_done_q     <= block_done_d;
            busy_q           <= busy_d;
        end
    end

    assign s_ready        = s_ready_q;
    assign w_out          = w_out_q;
    assign k_out          = k_out_q;
    assign round_valid    = round_valid_q;
    assign compress_start = compress_start_q;
    assign update_hash    = update_hash_q;
    assign block_done     = block_done_q;
    assign busy           = busy_q;

endmodule
